msrv_32_integer_file: RTL and testbench

MSRV_32_INTEGER_FILE -- requirements
Module: msrv_32_integer_file

---
 rtl/msrv_32_pkg.sv | 14 +
 rtl/msrv_32_integer_file.sv | 61 ++++++
 tb/tb_msrv_32_integer_file.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/msrv_32_pkg.sv
// ============================================================================
// msrv_32_pkg : shared widths and constants for the integer register file
// Revision 1.0
// ============================================================================
`default_nettype none

package msrv_32_pkg;
   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;
   localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;
endpackage

`default_nettype wire

// File: rtl/msrv_32_integer_file.sv
// ============================================================================
// msrv_32_integer_file : 32x32 register file, x0 hardwired to zero, two
// combinational read ports with write-through bypass. Revision 1.0
// ============================================================================
`default_nettype none

module msrv_32_integer_file
   import msrv_32_pkg::*;
(
   input  logic                  ms_risc32_mp_clk_in,
   input  logic                  ms_risc32_mp_rst_in,
   input  logic [REG_ADDR_W-1:0] rs_1_addr_in,
   input  logic [REG_ADDR_W-1:0] rs_2_addr_in,
   input  logic [REG_ADDR_W-1:0] rd_addr_in,
   input  logic [XLEN-1:0]       rd_in,
   input  logic                  wr_en_in,
   output logic [XLEN-1:0]       rs_1_out,
   output logic [XLEN-1:0]       rs_2_out
);

   logic [XLEN-1:0] regs [NUM_REGS];
   logic            wr_active;

   // Reset gates the bypass as well, so outputs are zero the instant reset asserts.
   assign wr_active = ms_risc32_mp_rst_in && wr_en_in && (rd_addr_in != ZERO_REG);

   always_ff @(posedge ms_risc32_mp_clk_in or negedge ms_risc32_mp_rst_in) begin
      if (!ms_risc32_mp_rst_in) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_active) begin
         regs[rd_addr_in] <= rd_in;
      end
   end

   always_comb begin
      rs_1_out = '0;
      if (!ms_risc32_mp_rst_in || rs_1_addr_in == ZERO_REG) begin
         rs_1_out = '0;
      end else if (wr_active && rs_1_addr_in == rd_addr_in) begin
         rs_1_out = rd_in;
      end else begin
         rs_1_out = regs[rs_1_addr_in];
      end
   end

   always_comb begin
      rs_2_out = '0;
      if (!ms_risc32_mp_rst_in || rs_2_addr_in == ZERO_REG) begin
         rs_2_out = '0;
      end else if (wr_active && rs_2_addr_in == rd_addr_in) begin
         rs_2_out = rd_in;
      end else begin
         rs_2_out = regs[rs_2_addr_in];
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_msrv_32_integer_file.sv
// ============================================================================
// tb_msrv_32_integer_file : directed stimulus with queue-based scoreboard
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_msrv_32_integer_file;

   logic        clk;
   logic        rst_n;
   logic [4:0]  rs1_a;
   logic [4:0]  rs2_a;
   logic [4:0]  rd_a;
   logic [31:0] rd_d;
   logic        wr_en;
   logic [31:0] rs1_q;
   logic [31:0] rs2_q;
   logic        strobe;

   typedef struct {
      logic [4:0]  a1;
      logic [4:0]  a2;
      logic [31:0] e1;
      logic [31:0] e2;
   } exp_t;

   exp_t sb[$];
   int   n_vec;
   int   n_err;

   msrv_32_integer_file dut (
      .ms_risc32_mp_clk_in (clk),
      .ms_risc32_mp_rst_in (rst_n),
      .rs_1_addr_in        (rs1_a),
      .rs_2_addr_in        (rs2_a),
      .rd_addr_in          (rd_a),
      .rd_in               (rd_d),
      .wr_en_in            (wr_en),
      .rs_1_out            (rs1_q),
      .rs_2_out            (rs2_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] pattern(input int i);
      return (i == 0) ? 32'h0 : ((32'(i) * 32'h01010101) ^ 32'hC000_0000);
   endfunction

   // Present read addresses, queue the expected data, then strobe the monitor.
   task automatic check(input logic [4:0] a1, input logic [4:0] a2,
                        input logic [31:0] e1, input logic [31:0] e2);
      exp_t e;
      rs1_a = a1;
      rs2_a = a2;
      #1;
      e.a1 = a1; e.a2 = a2; e.e1 = e1; e.e2 = e2;
      sb.push_back(e);
      strobe = 1'b1;
      #1;
      strobe = 1'b0;
   endtask

   task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      wr_en = 1'b1; rd_a = a; rd_d = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge strobe);
         if (sb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL sb_empty: strobe with no expected entry");
         end else begin
            e = sb.pop_front();
            n_vec++;
            if (rs1_q !== e.e1) begin
               n_err++;
               $display("FAIL rs1[x%0d] @%0t: got %08h want %08h", e.a1, $time, rs1_q, e.e1);
            end
            n_vec++;
            if (rs2_q !== e.e2) begin
               n_err++;
               $display("FAIL rs2[x%0d] @%0t: got %08h want %08h", e.a2, $time, rs2_q, e.e2);
            end
         end
      end
   end

   initial begin : stim
      int guard;
      n_vec = 0; n_err = 0;
      strobe = 1'b0;
      rst_n = 1'b0; wr_en = 1'b0; rd_a = '0; rd_d = '0; rs1_a = '0; rs2_a = '0;
      #2;
      for (int i = 0; i < 32; i++) check(5'(i), 5'(31 - i), 32'h0, 32'h0);

      // Writes and bypass blocked while in reset, across clock edges.
      wr_en = 1'b1; rd_a = 5'd3; rd_d = 32'h3333_3333;
      check(5'd3, 5'd3, 32'h0, 32'h0);
      repeat (2) @(negedge clk);
      check(5'd3, 5'd3, 32'h0, 32'h0);
      wr_en = 1'b0;
      rst_n = 1'b1;
      check(5'd3, 5'd3, 32'h0, 32'h0);

      write_reg(5'd1, 32'd15);
      check(5'd2, 5'd1, 32'h0, 32'h0000_000F);

      @(negedge clk);
      wr_en = 1'b1; rd_a = 5'd0; rd_d = 32'hDEAD_BEEF;
      check(5'd0, 5'd0, 32'h0, 32'h0);
      @(negedge clk);
      wr_en = 1'b0;
      check(5'd0, 5'd1, 32'h0, 32'h0000_000F);

      @(negedge clk);
      wr_en = 1'b1; rd_a = 5'd5; rd_d = 32'hA5A5_A5A5;
      check(5'd5, 5'd5, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
      check(5'd1, 5'd5, 32'h0000_000F, 32'hA5A5_A5A5);
      @(negedge clk);
      wr_en = 1'b0; rd_d = 32'h0;
      check(5'd5, 5'd5, 32'hA5A5_A5A5, 32'hA5A5_A5A5);

      @(negedge clk);
      wr_en = 1'b1; rd_a = 5'd7; rd_d = 32'h1;
      @(negedge clk);
      rd_d = 32'h2;
      @(negedge clk);
      wr_en = 1'b0; rd_d = 32'h3;
      check(5'd7, 5'd5, 32'h2, 32'hA5A5_A5A5);
      rd_d = 32'hFFFF_FFFF;
      @(negedge clk);
      check(5'd7, 5'd7, 32'h2, 32'h2);

      @(negedge clk);
      wr_en = 1'b1; rd_a = 5'd9; rd_d = 32'h99;
      check(5'd7, 5'd9, 32'h2, 32'h99);
      @(negedge clk);
      wr_en = 1'b0;
      check(5'd9, 5'd1, 32'h99, 32'h0000_000F);

      for (int i = 0; i < 32; i++) write_reg(5'(i), pattern(i));
      for (int i = 0; i < 32; i++) check(5'(i), 5'(31 - i), pattern(i), pattern(31 - i));

      write_reg(5'd31, 32'hFFFF_FFFF);
      write_reg(5'd30, 32'h1234_5678);
      check(5'd31, 5'd30, 32'hFFFF_FFFF, 32'h1234_5678);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      check(5'd31, 5'd30, 32'h0, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      check(5'd31, 5'd30, 32'h0, 32'h0);
      check(5'd1, 5'd7, 32'h0, 32'h0);

      write_reg(5'd4, 32'h4444_4444);
      check(5'd4, 5'd4, 32'h4444_4444, 32'h4444_4444);

      guard = 0;
      while (sb.size() != 0 && guard < 100) begin
         #1;
         guard++;
      end
      if (sb.size() != 0) begin
         n_vec++; n_err++;
         $display("FAIL sb_drain: %0d entries left, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
